proc_run_monitor: RTL and testbench
===================================

# proc_run_monitor

Synthesizable run controller and register-write tracer for the MIPS processor skeleton. It sequences the processor's reset for a parametrised number of cycles and runs it under a cycle budget. It detects program halt (PC self-loop) or budget timeout, counts architectural register writes and buffers them in a trace FIFO for readout. It sits beside the skeleton: it drives the skeleton's reset and observes the skeleton's imem address and regfile write port.

## Interface
Parameters:
- RESET_CYCLES, 1, cycles proc_reset stays high after start (≥1)
- MAX_CYCLES, 200, RUN-cycle budget before timeout (1..2^32-1)
- HALT_REPEAT, 4, consecutive unchanged address_imem samples declaring halt (≥2)
- TRACE_DEPTH, 16, trace FIFO entries (power of two, ≥2)
- ADDR_W, 12, address_imem width

Ports:
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; honoured in IDLE and DONE, ignored otherwise
- address_imem  in  ADDR_W  processor fetch address
- ctrl_writeEnable  in  1  regfile write strobe
- ctrl_writeReg  in  5  regfile write index
- data_writeReg  in  32  regfile write data
- proc_reset  out  1  reset to processor
- running  out  1  high in RUN
- done  out  1  high in DONE
- timeout  out  1  valid with done: 1 = budget exhausted, 0 = halt
- cycle_count  out  32  RUN cycles elapsed
- write_count  out  16  accepted register writes, saturating at 16'hFFFF
- trace_rd_en  in  1  pop FIFO head
- trace_valid  out  1  FIFO non-empty
- trace_reg  out  5  head entry register index
- trace_data  out  32  head entry data
- trace_level  out  $clog2(TRACE_DEPTH)+1  entries held
- trace_overflow  out  1  sticky: a write was dropped because FIFO full

## Operation
- Reset: state IDLE; proc_reset=1; running=0, done=0, timeout=0; cycle_count=0, write_count=0; FIFO empty; trace_overflow=0. A reset mid-run aborts immediately to these values.
- IDLE: proc_reset=1. start → RESET; counters, FIFO and overflow cleared on the same edge.
- RESET: proc_reset=1 for exactly RESET_CYCLES cycles, then RUN.
- RUN: proc_reset=0, running=1. cycle_count +1 per cycle. Halt tracker compares address_imem with its previous-cycle value; an equal value increments the repeat counter, any change sets it to 1. When the counter reaches HALT_REPEAT → DONE, timeout=0. When cycle_count would reach MAX_CYCLES → DONE, timeout=1. Both in the same cycle: halt wins, timeout=0.
- Accepted write: in RUN, ctrl_writeEnable=1 and ctrl_writeReg≠0. Writes to r0, or writes outside RUN, are neither counted nor traced.
- DONE: proc_reset=1, which freezes the processor. done, timeout and counters hold. FIFO remains readable. start → RESET with a full clear.
- FIFO: first-word fall-through. The head appears on trace_reg/trace_data whenever trace_valid=1. trace_rd_en while empty is ignored.
  - Full with push only: the entry is dropped, trace_overflow set; write_count still increments.
  - Full with push and pop in the same cycle: both succeed, level unchanged, no overflow.
  - Pointers wrap modulo TRACE_DEPTH.

## Timing
- All outputs registered; no combinational input→output paths except the FIFO head mux from registered storage.
- start at edge k: proc_reset is high for edges k+1..k+RESET_CYCLES, and running=1 from edge k+RESET_CYCLES+1.
- An accepted write at edge n is visible on trace_valid, trace_level and write_count after edge n.
- Timeout: done=1 on the edge where cycle_count becomes MAX_CYCLES, and cycle_count holds at MAX_CYCLES.
- Halt: done=1 one edge after the HALT_REPEAT-th equal sample.

## Configuration
- RUN_MON_TRACE_EN defined: the trace FIFO and its ports operate as specified.
- RUN_MON_TRACE_EN undefined: no FIFO storage is built. trace_valid, trace_reg, trace_data, trace_level and trace_overflow are tied to 0, and trace_rd_en is ignored. write_count and all control behaviour are unchanged.

## Test plan
- Reset then start, RESET_CYCLES=3 → proc_reset high exactly 3 cycles after start; running rises on the 4th edge.
- PC increments forever, MAX_CYCLES=200 → done=1, timeout=1, cycle_count=200, proc_reset=1.
- PC sticks at 12'h010 from cycle 20, HALT_REPEAT=4 → done=1, timeout=0, cycle_count=23.
- Writes r5=32'h1234, r0=32'hFFFF, r7=32'hABCD → write_count=2; popping yields (5,1234) then (7,ABCD), then trace_valid=0.
- TRACE_DEPTH=4: 6 writes with no reads → trace_level=4, trace_overflow=1, write_count=6. A push and a pop in the same cycle while full → level stays 4.
- Reset asserted mid-RUN, then start → all counters 0, FIFO empty, full RESET sequence replayed.

Source files
------------

// File: rtl/proc_run_monitor.sv
// Run controller and register-write tracer for the MIPS skeleton: sequences processor reset,
// runs under a cycle budget, detects PC self-loop halt. Trace FIFO built only with RUN_MON_TRACE_EN.
module proc_run_monitor #(
    parameter int          RESET_CYCLES = 1,
    parameter logic [31:0] MAX_CYCLES   = 32'd200,
    parameter int          HALT_REPEAT  = 4,
    parameter int          TRACE_DEPTH  = 16,
    parameter int          ADDR_W       = 12
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              address_imem,
    input  logic                           ctrl_writeEnable,
    input  logic [4:0]                     ctrl_writeReg,
    input  logic [31:0]                    data_writeReg,
    output logic                           proc_reset,
    output logic                           running,
    output logic                           done,
    output logic                           timeout,
    output logic [31:0]                    cycle_count,
    output logic [15:0]                    write_count,
    input  logic                           trace_rd_en,
    output logic                           trace_valid,
    output logic [4:0]                     trace_reg,
    output logic [31:0]                    trace_data,
    output logic [$clog2(TRACE_DEPTH):0]   trace_level,
    output logic                           trace_overflow
);

    localparam int LVL_W = $clog2(TRACE_DEPTH) + 1;
    localparam int REP_W = $clog2(HALT_REPEAT + 1);
    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LIM  = REP_W'(HALT_REPEAT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [RST_W-1:0]  rst_cnt_r;
    logic [REP_W-1:0]  rep_r, rep_s;
    logic [ADDR_W-1:0] prev_addr_r;
    logic [31:0]       cycle_count_r, cyc_inc_s;
    logic [15:0]       write_count_r;
    logic              proc_reset_r, running_r, done_r, timeout_r;
    logic              clear_s, accept_s, halt_hit_s, tmo_hit_s;

    // Halt tracker, budget check and next-state decode
    always_comb begin
        rep_s      = REP_W'(1'b1);
        state_s    = state_r;
        if ((rep_r != {REP_W{1'b0}}) && (address_imem == prev_addr_r)) begin
            if (rep_r == REP_LIM) begin
                rep_s = rep_r;
            end else begin
                rep_s = rep_r + REP_W'(1'b1);
            end
        end else begin
            rep_s = REP_W'(1'b1);
        end
        halt_hit_s = (rep_s == REP_LIM);
        cyc_inc_s  = cycle_count_r + 32'd1;
        tmo_hit_s  = (cyc_inc_s == MAX_CYCLES);
        clear_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        accept_s   = (state_r == ST_RUN) && ctrl_writeEnable && (ctrl_writeReg != 5'd0);
        case (state_r)
            ST_IDLE:  state_s = start ? ST_RESET : ST_IDLE;
            ST_RESET: state_s = (rst_cnt_r == {RST_W{1'b0}}) ? ST_RUN : ST_RESET;
            ST_RUN: begin
                if (halt_hit_s || tmo_hit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE:  state_s = start ? ST_RESET : ST_DONE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register, run counters and registered control outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            rst_cnt_r     <= {RST_W{1'b0}};
            rep_r         <= {REP_W{1'b0}};
            prev_addr_r   <= {ADDR_W{1'b0}};
            cycle_count_r <= 32'd0;
            proc_reset_r  <= 1'b1;
            running_r     <= 1'b0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            proc_reset_r <= (state_s != ST_RUN);
            running_r    <= (state_s == ST_RUN);
            done_r       <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (clear_s) begin
                        rst_cnt_r     <= RST_LOAD;
                        rep_r         <= {REP_W{1'b0}};
                        cycle_count_r <= 32'd0;
                        timeout_r     <= 1'b0;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt_r != {RST_W{1'b0}}) begin
                        rst_cnt_r <= rst_cnt_r - RST_W'(1'b1);
                    end
                end
                ST_RUN: begin
                    cycle_count_r <= cyc_inc_s;
                    rep_r         <= rep_s;
                    prev_addr_r   <= address_imem;
                    // halt outranks budget exhaustion when both land together
                    timeout_r     <= tmo_hit_s && !halt_hit_s;
                end
                default: begin
                    rep_r <= {REP_W{1'b0}};
                end
            endcase
        end
    end

    // Saturating count of accepted register writes
    always_ff @(posedge clock) begin
        if (reset || clear_s) begin
            write_count_r <= 16'd0;
        end else if (accept_s && (write_count_r != 16'hFFFF)) begin
            write_count_r <= write_count_r + 16'd1;
        end
    end

    assign proc_reset  = proc_reset_r;
    assign running     = running_r;
    assign done        = done_r;
    assign timeout     = timeout_r;
    assign cycle_count = cycle_count_r;
    assign write_count = write_count_r;

`ifdef RUN_MON_TRACE_EN
    localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(TRACE_DEPTH);

    logic [4:0]       mem_reg_r  [TRACE_DEPTH];
    logic [31:0]      mem_data_r [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0] level_r, level_s;
    logic             valid_r, overflow_r;
    logic             full_s, pop_s, push_s;

    // Push/pop arbitration: a full FIFO still accepts a push when popped the same cycle
    always_comb begin
        full_s  = (level_r == LVL_FULL);
        pop_s   = trace_rd_en && (level_r != {LVL_W{1'b0}});
        push_s  = accept_s && (!full_s || pop_s);
        level_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + LVL_W'(1'b1);
            2'b01:   level_s = level_r - LVL_W'(1'b1);
            default: level_s = level_r;
        endcase
    end

    // Trace storage, written only on an accepted push
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_reg_r[wr_ptr_r]  <= ctrl_writeReg;
            mem_data_r[wr_ptr_r] <= data_writeReg;
        end
    end

    // FIFO pointers, level and sticky overflow
    always_ff @(posedge clock) begin
        if (reset || clear_s) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= {LVL_W{1'b0}};
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            level_r <= level_s;
            valid_r <= (level_s != {LVL_W{1'b0}});
            if (accept_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign trace_valid    = valid_r;
    assign trace_reg      = mem_reg_r[rd_ptr_r];
    assign trace_data     = mem_data_r[rd_ptr_r];
    assign trace_level    = level_r;
    assign trace_overflow = overflow_r;
`else
    logic unused_trace_s;
    assign unused_trace_s = trace_rd_en ^ (^data_writeReg);

    assign trace_valid    = 1'b0;
    assign trace_reg      = 5'd0;
    assign trace_data     = 32'd0;
    assign trace_level    = {LVL_W{1'b0}};
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_proc_run_monitor.sv
// Directed bench for proc_run_monitor: reset sequencing, timeout, halt, write trace, overflow, mid-run reset.
module tb_proc_run_monitor;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [11:0] address_imem;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        proc_reset, running, done, timeout;
    logic [31:0] cycle_count;
    logic [15:0] write_count;
    logic        trace_rd_en, trace_valid;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
    logic [2:0]  trace_level;
    logic        trace_overflow;

    int errors = 0;
    int checks = 0;
    logic stick_mode = 1'b0;
    logic [31:0] prev_cc;

    proc_run_monitor #(
        .RESET_CYCLES(3), .MAX_CYCLES(32'd200), .HALT_REPEAT(4), .TRACE_DEPTH(4), .ADDR_W(12)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .address_imem(address_imem),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .proc_reset(proc_reset), .running(running),
        .done(done), .timeout(timeout), .cycle_count(cycle_count), .write_count(write_count),
        .trace_rd_en(trace_rd_en), .trace_valid(trace_valid), .trace_reg(trace_reg),
        .trace_data(trace_data), .trace_level(trace_level), .trace_overflow(trace_overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_trace(input string tag, input logic exp_valid, input logic [2:0] exp_level,
                             input logic [4:0] exp_reg, input logic [31:0] exp_data,
                             input logic exp_ovf);
`ifdef RUN_MON_TRACE_EN
        chk({tag, "_valid"}, {31'd0, trace_valid}, {31'd0, exp_valid});
        chk({tag, "_level"}, {29'd0, trace_level}, {29'd0, exp_level});
        chk({tag, "_ovf"}, {31'd0, trace_overflow}, {31'd0, exp_ovf});
        if (exp_valid) begin
            chk({tag, "_reg"}, {27'd0, trace_reg}, {27'd0, exp_reg});
            chk({tag, "_data"}, trace_data, exp_data);
        end
`else
        chk({tag, "_valid"}, {31'd0, trace_valid}, 32'd0);
        chk({tag, "_level"}, {29'd0, trace_level}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, trace_overflow}, 32'd0);
        chk({tag, "_reg"}, {27'd0, trace_reg}, 32'd0);
        chk({tag, "_data"}, trace_data, 32'd0);
`endif
    endtask

    // Advance one edge, then model the processor PC from the run cycle count
    task automatic tick();
        @(posedge clock);
        #1;
        if (stick_mode && (cycle_count >= 32'd19)) address_imem = 12'h010;
        else address_imem = 12'h100 + cycle_count[11:0] * 12'd4;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = r;
        data_writeReg    = d;
        tick();
        ctrl_writeEnable = 1'b0;
    endtask

    task automatic pop();
        trace_rd_en = 1'b1;
        tick();
        trace_rd_en = 1'b0;
    endtask

    task automatic start_and_check_reset_seq(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_pr_hi"}, {31'd0, proc_reset}, 32'd1);
            chk({tag, "_run_lo"}, {31'd0, running}, 32'd0);
            tick();
        end
        chk({tag, "_pr_lo"}, {31'd0, proc_reset}, 32'd0);
        chk({tag, "_run_hi"}, {31'd0, running}, 32'd1);
        chk({tag, "_cc0"}, cycle_count, 32'd0);
    endtask

    initial begin
        logic [4:0]  exp_r [4];
        logic [31:0] exp_d [4];
        int guard;
        reset = 1'b1; start = 1'b0; address_imem = 12'h000;
        ctrl_writeEnable = 1'b0; ctrl_writeReg = 5'd0; data_writeReg = 32'd0; trace_rd_en = 1'b0;
        tick(); tick(); tick();
        chk("rst_proc_reset", {31'd0, proc_reset}, 32'd1);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_cc", cycle_count, 32'd0);
        chk("rst_wc", {16'd0, write_count}, 32'd0);
        chk_trace("rst_fifo", 1'b0, 3'd0, 5'd0, 32'd0, 1'b0);
        reset = 1'b0;
        tick();
        chk("idle_pr", {31'd0, proc_reset}, 32'd1);

        // Reset sequence and basic write tracing
        start_and_check_reset_seq("seq1");
        wr(5'd5, 32'h1234);
        wr(5'd0, 32'hFFFF);
        wr(5'd7, 32'hABCD);
        chk("wc_skip_r0", {16'd0, write_count}, 32'd2);
        chk_trace("trace_two", 1'b1, 3'd2, 5'd5, 32'h1234, 1'b0);
        pop();
        chk_trace("trace_pop1", 1'b1, 3'd1, 5'd7, 32'hABCD, 1'b0);
        pop();
        chk_trace("trace_pop2", 1'b0, 3'd0, 5'd0, 32'd0, 1'b0);
        pop();
        chk_trace("trace_pop_empty", 1'b0, 3'd0, 5'd0, 32'd0, 1'b0);

        // Budget exhaustion with a PC that never repeats
        guard = 0;
        prev_cc = cycle_count;
        while (!done && guard < 400) begin
            prev_cc = cycle_count;
            tick();
            guard++;
        end
        chk("tmo_done", {31'd0, done}, 32'd1);
        chk("tmo_prev_cc", prev_cc, 32'd199);
        chk("tmo_cc", cycle_count, 32'd200);
        chk("tmo_timeout", {31'd0, timeout}, 32'd1);
        chk("tmo_pr", {31'd0, proc_reset}, 32'd1);
        chk("tmo_running", {31'd0, running}, 32'd0);
        wr(5'd3, 32'h55);
        tick();
        chk("done_hold_cc", cycle_count, 32'd200);
        chk("done_hold_done", {31'd0, done}, 32'd1);
        chk("done_write_ignored", {16'd0, write_count}, 32'd2);

        // Halt on PC self-loop
        stick_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_cc", cycle_count, 32'd0);
        chk("restart_wc", {16'd0, write_count}, 32'd0);
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_timeout", {31'd0, timeout}, 32'd0);
        guard = 0;
        while (!done && guard < 100) begin
            prev_cc = cycle_count;
            tick();
            guard++;
        end
        chk("halt_done", {31'd0, done}, 32'd1);
        chk("halt_prev_cc", prev_cc, 32'd22);
        chk("halt_cc", cycle_count, 32'd23);
        chk("halt_timeout", {31'd0, timeout}, 32'd0);
        chk("halt_pr", {31'd0, proc_reset}, 32'd1);

        // FIFO overflow and simultaneous push/pop while full
        stick_mode = 1'b0;
        start_and_check_reset_seq("seq2");
        for (int i = 1; i <= 6; i++) wr(5'(i), 32'hA0 + 32'(i));
        chk("ovf_wc", {16'd0, write_count}, 32'd6);
        chk_trace("ovf_full", 1'b1, 3'd4, 5'd1, 32'hA1, 1'b1);
        trace_rd_en = 1'b1;
        wr(5'd9, 32'h99);
        trace_rd_en = 1'b0;
        chk("pushpop_wc", {16'd0, write_count}, 32'd7);
        chk_trace("pushpop_full", 1'b1, 3'd4, 5'd2, 32'hA2, 1'b1);
        exp_r[0] = 5'd3; exp_r[1] = 5'd4; exp_r[2] = 5'd9;
        exp_d[0] = 32'hA3; exp_d[1] = 32'hA4; exp_d[2] = 32'h99;
        for (int i = 0; i < 3; i++) begin
            pop();
            chk_trace("drain", 1'b1, 3'(3 - i), exp_r[i], exp_d[i], 1'b1);
        end
        pop();
        chk_trace("drain_empty", 1'b0, 3'd0, 5'd0, 32'd0, 1'b1);

        // Reset mid-run, then replay the full start sequence
        wr(5'd2, 32'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_pr", {31'd0, proc_reset}, 32'd1);
        chk("midrst_running", {31'd0, running}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_cc", cycle_count, 32'd0);
        chk("midrst_wc", {16'd0, write_count}, 32'd0);
        chk_trace("midrst_fifo", 1'b0, 3'd0, 5'd0, 32'd0, 1'b0);
        tick();
        chk("midrst_idle_pr", {31'd0, proc_reset}, 32'd1);
        start_and_check_reset_seq("seq3");
        tick();
        chk("seq3_cc1", cycle_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
